// File: rtl/tap_delay_mem_if.sv
// Write/read-burst bus of the tap delay memory: sample writes in,
// newest-first burst out with valid/last framing and a reject pulse.
interface tap_delay_mem_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 7
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_start;
    logic [ADDR_W:0]   rd_len;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_err;

    modport master (
        output wr_valid, wr_data, rd_start, rd_len,
        input  wr_ready, rd_valid, rd_data, rd_last, rd_err
    );

    modport slave (
        input  wr_valid, wr_data, rd_start, rd_len,
        output wr_ready, rd_valid, rd_data, rd_last, rd_err
    );
endinterface

// File: rtl/tap_delay_mem.sv
// Circular sample buffer on a single-port block RAM; reads bursts of the
// most recent samples newest-first for a FIR multiply-accumulate chain.
module tap_delay_mem #(
    parameter int DATA_W  = 18,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_i,
    tap_delay_mem_if.slave    bus,
    output logic              busy_o,
    output logic [ADDR_W:0]   count_o
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d, ra_q, ra_d;
    logic [ADDR_W:0]   count_q, count_d, rem_q, rem_d;
    logic              drain_q, drain_d;
    logic              err_q, err_d;
    logic              v1_q, l1_q;

    logic              wr_acc, issue, start_ok;
    logic [ADDR_W-1:0] wp_eff, ram_addr;
    logic [ADDR_W:0]   count_eff;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] ram_q;

    // A write accepted this cycle is visible to a simultaneous burst request.
    assign wr_acc    = (state_q == IDLE) && bus.wr_valid;
    assign issue     = (state_q == READ);
    assign wp_eff    = wr_acc ? wp_q + ONE_A : wp_q;
    assign count_eff = (wr_acc && count_q != DEPTH_C) ? count_q + ONE_C : count_q;
    assign start_ok  = bus.rd_start && (bus.rd_len != '0) && (bus.rd_len <= count_eff);
    assign ram_addr  = issue ? ra_q : wp_q;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        count_d = count_q;
        ra_d    = ra_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                wp_d    = wp_eff;
                count_d = count_eff;
                if (bus.rd_start) begin
                    if (start_ok) begin
                        state_d = READ;
                        ra_d    = wp_eff - ONE_A;
                        rem_d   = bus.rd_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: begin
                ra_d  = ra_q - ONE_A;
                rem_d = rem_q - ONE_C;
                if (rem_q == ONE_C) begin
                    state_d = DRAIN;
                    drain_d = (OUT_REG != 0);
                end
            end
            DRAIN: begin
                if (drain_q) drain_d = 1'b0;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wp_q    <= '0;
            count_q <= '0;
            ra_q    <= '0;
            rem_q   <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
            v1_q    <= 1'b0;
            l1_q    <= 1'b0;
        end else if (ce_i) begin
            state_q <= state_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            ra_q    <= ra_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            v1_q    <= issue;
            l1_q    <= issue && (rem_q == ONE_C);
        end
    end

    // Writes only happen in IDLE and reads only in READ, so one port suffices.
    always_ff @(posedge clk) begin
        if (ce_i) begin
            if (wr_acc) mem_q[ram_addr] <= bus.wr_data;
            if (issue)  ram_q <= mem_q[ram_addr];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              v2_q, l2_q;
            logic [DATA_W-1:0] out_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v2_q  <= 1'b0;
                    l2_q  <= 1'b0;
                    out_q <= '0;
                end else if (ce_i) begin
                    v2_q <= v1_q;
                    l2_q <= l1_q;
                    if (v1_q) out_q <= ram_q;
                end
            end
            assign bus.rd_valid = v2_q;
            assign bus.rd_last  = l2_q;
            assign bus.rd_data  = out_q;
        end else begin : g_noreg
            // RAM read register has no reset; mask it until a read has landed.
            logic seen_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)               seen_q <= 1'b0;
                else if (ce_i && issue)  seen_q <= 1'b1;
            end
            assign bus.rd_valid = v1_q;
            assign bus.rd_last  = l1_q;
            assign bus.rd_data  = seen_q ? ram_q : '0;
        end
    endgenerate

    assign bus.wr_ready = (state_q == IDLE);
    assign bus.rd_err   = err_q;
    assign busy_o       = (state_q != IDLE);
    assign count_o      = count_q;
endmodule

// File: tb/tb_tap_delay_mem.sv
// Drives identical stimulus into a registered-output and an unregistered-output
// instance and checks both against a newest-first sample-history model.
module tb_tap_delay_mem;
    localparam int DW    = 18;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b1;
    logic          wr_valid = 1'b0;
    logic          rd_start = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   rd_len = '0;

    always #5 clk = ~clk;

    tap_delay_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus_r ();
    tap_delay_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus_c ();

    assign bus_r.wr_valid = wr_valid;
    assign bus_r.wr_data  = wr_data;
    assign bus_r.rd_start = rd_start;
    assign bus_r.rd_len   = rd_len;
    assign bus_c.wr_valid = wr_valid;
    assign bus_c.wr_data  = wr_data;
    assign bus_c.rd_start = rd_start;
    assign bus_c.rd_len   = rd_len;

    logic        busy_r, busy_c;
    logic [AW:0] count_r, count_c;

    tap_delay_mem #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_REG(1)) dut_r (
        .clk(clk), .reset(reset), .ce_i(ce), .bus(bus_r), .busy_o(busy_r), .count_o(count_r)
    );
    tap_delay_mem #(.DATA_W(DW), .DEPTH(DEPTH), .OUT_REG(0)) dut_c (
        .clk(clk), .reset(reset), .ce_i(ce), .bus(bus_c), .busy_o(busy_c), .count_o(count_c)
    );

    logic          o_valid [2];
    logic          o_last  [2];
    logic          o_err   [2];
    logic          o_busy  [2];
    logic          o_ready [2];
    logic [DW-1:0] o_data  [2];
    logic [AW:0]   o_count [2];

    assign o_valid[0] = bus_r.rd_valid;  assign o_valid[1] = bus_c.rd_valid;
    assign o_last[0]  = bus_r.rd_last;   assign o_last[1]  = bus_c.rd_last;
    assign o_err[0]   = bus_r.rd_err;    assign o_err[1]   = bus_c.rd_err;
    assign o_ready[0] = bus_r.wr_ready;  assign o_ready[1] = bus_c.wr_ready;
    assign o_data[0]  = bus_r.rd_data;   assign o_data[1]  = bus_c.rd_data;
    assign o_busy[0]  = busy_r;          assign o_busy[1]  = busy_c;
    assign o_count[0] = count_r;         assign o_count[1] = count_c;

    int checks = 0;
    int errors = 0;

    // hist[0] is the newest stored sample; at most DEPTH entries survive.
    logic [DW-1:0] hist [$];
    logic [DW-1:0] last_data = '0;

    function automatic void model_write(input logic [DW-1:0] v);
        hist.push_front(v);
        if (hist.size() > DEPTH) void'(hist.pop_back());
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce = 1'b1;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_valid[d], o_last[d], o_err[d], o_busy[d], o_ready[d]} !== 5'b00001) begin
                errors++;
                $display("FAIL reset_ctl dut%0d v/l/e/b/r got %b want 00001", d,
                         {o_valid[d], o_last[d], o_err[d], o_busy[d], o_ready[d]});
            end
            checks++;
            if (o_count[d] !== '0 || o_data[d] !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d count=%0d data=%0h want 0/0", d, o_count[d], o_data[d]);
            end
        end
        reset = 1'b0;
        step();
        hist.delete();
        last_data = '0;
    endtask

    task automatic test_write(input int n, input bit rnd, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr_data  = rnd ? DW'($urandom) : base + DW'(i);
            wr_valid = 1'b1;
            step();
            model_write(wr_data);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_count[d] !== (AW + 1)'(hist.size()) || o_ready[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL write_count dut%0d count=%0d ready=%b want %0d/1", d, o_count[d],
                             o_ready[d], hist.size());
                end
            end
            $display("write data=%0h count=%0d", wr_data, hist.size());
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_ce_write();
        ce = 1'b0;
        wr_valid = 1'b1;
        wr_data = DW'($urandom);
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_count[d] !== (AW + 1)'(hist.size())) begin
                errors++;
                $display("FAIL ce_write dut%0d count=%0d want %0d", d, o_count[d], hist.size());
            end
        end
        wr_valid = 1'b0;
        ce = 1'b1;
        $display("ce-low write ignored count=%0d", hist.size());
    endtask

    task automatic test_error(input int len, input bit do_wr, input logic [DW-1:0] wdata);
        rd_start = 1'b1;
        rd_len   = (AW + 1)'(len);
        wr_valid = do_wr;
        wr_data  = wdata;
        ce = 1'b1;
        step();
        if (do_wr) model_write(wdata);
        rd_start = 1'b0;
        wr_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_err[d], o_valid[d], o_busy[d]} !== 3'b100) begin
                errors++;
                $display("FAIL err_pulse dut%0d e/v/b got %b want 100", d, {o_err[d], o_valid[d], o_busy[d]});
            end
            checks++;
            if (o_count[d] !== (AW + 1)'(hist.size())) begin
                errors++;
                $display("FAIL err_count dut%0d count=%0d want %0d", d, o_count[d], hist.size());
            end
        end
        ce = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_err[d] !== 1'b1) begin
                errors++;
                $display("FAIL err_hold dut%0d err=%b want 1", d, o_err[d]);
            end
        end
        ce = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_err[d], o_valid[d]} !== 2'b00) begin
                errors++;
                $display("FAIL err_clear dut%0d e/v got %b want 00", d, {o_err[d], o_valid[d]});
            end
        end
        $display("reject len=%0d wr=%0b count=%0d", len, do_wr, hist.size());
    endtask

    // e counts clock-enabled edges since the one that accepted rd_start (e=0).
    task automatic test_burst(input int len, input bit do_wr, input logic [DW-1:0] wdata,
                              input int stall_at, input int stall_n, input bit poke);
        logic [DW-1:0] exp [$];
        int  k = 0;
        int  e = 0;
        int  stalls = 0;
        bit  ce_edge;
        bit  done = 1'b0;
        bit  v, l, b;
        int  lat;
        logic [DW-1:0] dexp;
        if (do_wr) model_write(wdata);
        for (int i = 0; i < len; i++) exp.push_back(hist[i]);
        rd_start = 1'b1;
        rd_len   = (AW + 1)'(len);
        wr_valid = do_wr;
        wr_data  = wdata;
        ce = 1'b1;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            ce_edge = ce;
            step();
            if (ce_edge) k++;
            e = k - 1;
            rd_start = 1'b0;
            wr_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? 1 : 0;
                v = (e >= 1 + lat) && (e <= len + lat);
                l = (e == len + lat);
                b = (e <= len + lat);
                if (v)              dexp = exp[e - 1 - lat];
                else if (e < 1 + lat) dexp = last_data;
                else                dexp = exp[len - 1];
                checks++;
                if ({o_valid[d], o_last[d], o_busy[d], o_ready[d], o_err[d]} !== {v, l, b, !b, 1'b0}) begin
                    errors++;
                    $display("FAIL burst_ctl dut%0d e=%0d v/l/b/r/e got %b want %b", d, e,
                             {o_valid[d], o_last[d], o_busy[d], o_ready[d], o_err[d]}, {v, l, b, !b, 1'b0});
                end
                checks++;
                if (o_data[d] !== dexp) begin
                    errors++;
                    $display("FAIL burst_data dut%0d e=%0d got %0h want %0h", d, e, o_data[d], dexp);
                end
            end
            if (poke && k == 2) begin
                rd_start = 1'b1;
                rd_len   = (AW + 1)'(1);
            end
            if (stall_n > 0 && k >= stall_at && stalls < stall_n) begin
                ce = 1'b0;
                stalls++;
            end else begin
                ce = 1'b1;
            end
            done = (e >= len + 2);
        end
        rd_start = 1'b0;
        ce = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout len=%0d e=%0d", len, e);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_count[d] !== (AW + 1)'(hist.size())) begin
                errors++;
                $display("FAIL burst_count dut%0d count=%0d want %0d", d, o_count[d], hist.size());
            end
        end
        last_data = exp[len - 1];
        $display("burst len=%0d wr=%0b stall=%0d@%0d poke=%0b first=%0h last=%0h", len, do_wr, stall_n,
                 stall_at, poke, exp[0], exp[len - 1]);
    endtask

    task automatic test_reset_midburst(input int len);
        rd_start = 1'b1;
        rd_len   = (AW + 1)'(len);
        ce = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_valid[d], o_last[d], o_busy[d], o_ready[d]} !== 4'b0001 ||
                o_count[d] !== '0 || o_data[d] !== '0) begin
                errors++;
                $display("FAIL reset_mid dut%0d v/l/b/r=%b count=%0d data=%0h want 0001/0/0", d,
                         {o_valid[d], o_last[d], o_busy[d], o_ready[d]}, o_count[d], o_data[d]);
            end
        end
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({o_valid[d], o_busy[d]} !== 2'b00) begin
                    errors++;
                    $display("FAIL reset_after dut%0d v/b got %b want 00", d, {o_valid[d], o_busy[d]});
                end
            end
        end
        hist.delete();
        last_data = '0;
        $display("reset mid-burst len=%0d", len);
    endtask

    initial begin
        int nw, ln, maxl, ce_cnt;
        bit dw;
        test_reset();
        test_write(3, 1'b0, DW'(1));
        test_burst(3, 1'b0, '0, -1, 0, 1'b0);
        test_error(0, 1'b0, '0);
        test_error(4, 1'b0, '0);
        test_ce_write();
        test_write(7, 1'b0, DW'(4));
        test_burst(8, 1'b0, '0, -1, 0, 1'b0);
        test_burst(5, 1'b0, '0, 3, 3, 1'b1);
        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(0, 4);
            test_write(nw, 1'b1, '0);
            dw = 1'($urandom_range(0, 1));
            if (hist.size() == 0) dw = 1'b1;
            maxl = hist.size() + int'(dw);
            if (maxl > DEPTH) maxl = DEPTH;
            ln = $urandom_range(1, maxl);
            test_burst(ln, dw, DW'($urandom), $urandom_range(1, ln + 2), $urandom_range(0, 3), ln >= 3);
            if (it % 3 == 0) begin
                ce_cnt = (hist.size() + 1 > DEPTH) ? DEPTH : hist.size() + 1;
                test_error(ce_cnt + 1, 1'b1, DW'($urandom));
            end
        end
        test_reset_midburst(5);
        test_write(2, 1'b1, '0);
        test_burst(1, 1'b1, DW'(20), -1, 0, 1'b0);
        test_burst(hist.size() + 1, 1'b1, DW'($urandom), -1, 0, 1'b0);
        test_error(hist.size() + 2, 1'b1, DW'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
